// File: rtl/dht22_reader_if.sv
// Control/result bundle between system logic and the DHT22 reader.
// Latency: none (wires only).
// Backpressure: none; data_ready is a one-cycle strobe with no ready.
// Ports: start_read (request), data_ready (strobe), sys_idle (status),
//        humidity_bcd / temperature_bcd ([2]=tens,[1]=units,[0]=tenths),
//        negativo_temp (temperature sign).
interface dht22_reader_if;
  logic            start_read;
  logic            data_ready;
  logic            sys_idle;
  logic [2:0][3:0] humidity_bcd;
  logic            negativo_temp;
  logic [2:0][3:0] temperature_bcd;

  // System controller side.
  modport master (
    output start_read,
    input  data_ready, sys_idle, humidity_bcd, negativo_temp, temperature_bcd
  );

  // Reader side.
  modport slave (
    input  start_read,
    output data_ready, sys_idle, humidity_bcd, negativo_temp, temperature_bcd
  );
endinterface

// File: rtl/dht22_reader.sv
// DHT22 single-wire host: start pulse, 40-bit frame decode, checksum, BCD out.
// Latency: ~1 ms start + sensor frame, then 1 check + 10 convert + 1 done cycle.
// Backpressure: none; start_read only honoured in IDLE, data_ready is a strobe.
// Ports: clk, arstn (async active-low), bus (dht22_reader_if.slave: start_read,
//        data_ready, sys_idle, humidity_bcd, negativo_temp, temperature_bcd),
//        dht22_in_out (open-drain sensor line, driven 0 or Z only).
module dht22_reader #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic           clk,
  input  logic           arstn,
  dht22_reader_if.slave  bus,
  inout  wire            dht22_in_out
);

  localparam int CYC_PER_US = CLK_FREQ / 1_000_000;
  localparam int TW         = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CYC_PER_US - 1);

  localparam logic [10:0] START_LAST  = 11'd999;  // 1000 us host low
  localparam logic [10:0] TIMEOUT_US  = 11'd200;  // abort when exceeded
  localparam logic [10:0] BIT1_THRESH = 11'd50;   // high > 50 us means '1'

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_LOW,
    S_WAIT_RESP,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t       state;
  logic         drive_low;
  logic [TW-1:0] tick_cnt;
  logic         tick;
  logic [10:0]  us_cnt;
  logic [2:0]   line_sh;
  logic         line_rise;
  logic         line_fall;
  logic         timed_out;
  logic [5:0]   bit_cnt;
  logic [39:0]  frame;
  logic [7:0]   chk_sum;
  logic [9:0]   hum_bin;
  logic [9:0]   tmp_bin;
  logic [11:0]  hum_acc;
  logic [11:0]  tmp_acc;
  logic         neg_q;
  logic [3:0]   conv_cnt;

  // Open drain: only ever pull low, the external pull-up provides the high.
  assign dht22_in_out = drive_low ? 1'b0 : 1'bz;

  // Values above 999 tenths cannot be shown in three digits.
  function automatic logic [9:0] sat999(input logic [15:0] v);
    return (v > 16'd999) ? 10'd999 : v[9:0];
  endfunction

  // One double-dabble iteration: add 3 to digits >= 5, then shift in b.
  function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic b);
    logic [11:0] adj;
    for (int i = 0; i < 3; i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    return {adj[10:0], b};
  endfunction

  // Free-running microsecond tick.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  // line_sh[1:0] is the two-flop synchronizer, line_sh[2] the edge history.
  // Reset to 1 so the idle-high line shows no spurious edge after reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      line_sh <= 3'b111;
    end else begin
      line_sh <= {line_sh[1:0], dht22_in_out};
    end
  end

  assign line_rise = line_sh[1] & ~line_sh[2];
  assign line_fall = ~line_sh[1] & line_sh[2];
  assign timed_out = (us_cnt > TIMEOUT_US);
  assign chk_sum   = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state               <= S_IDLE;
      drive_low           <= 1'b0;
      us_cnt              <= '0;
      bit_cnt             <= '0;
      frame               <= '0;
      hum_bin             <= '0;
      tmp_bin             <= '0;
      hum_acc             <= '0;
      tmp_acc             <= '0;
      neg_q               <= 1'b0;
      conv_cnt            <= '0;
      bus.sys_idle        <= 1'b1;
      bus.data_ready      <= 1'b0;
      bus.humidity_bcd    <= '0;
      bus.temperature_bcd <= '0;
      bus.negativo_temp   <= 1'b0;
    end else begin
      bus.data_ready <= 1'b0;
      // Phase timer; every state change below overrides this with a clear.
      if (tick && (us_cnt != '1)) begin
        us_cnt <= us_cnt + 11'd1;
      end

      case (state)
        S_IDLE: begin
          if (bus.start_read) begin
            state        <= S_START_LOW;
            drive_low    <= 1'b1;
            bus.sys_idle <= 1'b0;
            us_cnt       <= '0;
          end
        end

        S_START_LOW: begin
          if (tick && (us_cnt == START_LAST)) begin
            state     <= S_WAIT_RESP;
            drive_low <= 1'b0;
            us_cnt    <= '0;
          end
        end

        S_WAIT_RESP: begin
          if (line_fall) begin
            state  <= S_RESP_LOW;
            us_cnt <= '0;
          end else if (timed_out) begin
            state        <= S_IDLE;
            bus.sys_idle <= 1'b1;
            us_cnt       <= '0;
          end
        end

        S_RESP_LOW: begin
          if (line_rise) begin
            state  <= S_RESP_HIGH;
            us_cnt <= '0;
          end else if (timed_out) begin
            state        <= S_IDLE;
            bus.sys_idle <= 1'b1;
            us_cnt       <= '0;
          end
        end

        S_RESP_HIGH: begin
          if (line_fall) begin
            state   <= S_BIT_LOW;
            bit_cnt <= '0;
            us_cnt  <= '0;
          end else if (timed_out) begin
            state        <= S_IDLE;
            bus.sys_idle <= 1'b1;
            us_cnt       <= '0;
          end
        end

        S_BIT_LOW: begin
          if (line_rise) begin
            state  <= S_BIT_HIGH;
            us_cnt <= '0;
          end else if (timed_out) begin
            state        <= S_IDLE;
            bus.sys_idle <= 1'b1;
            us_cnt       <= '0;
          end
        end

        S_BIT_HIGH: begin
          if (line_fall) begin
            // The bit value is encoded in how long the sensor held the line high.
            frame   <= {frame[38:0], (us_cnt > BIT1_THRESH)};
            bit_cnt <= bit_cnt + 6'd1;
            us_cnt  <= '0;
            state   <= (bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
          end else if (timed_out) begin
            state        <= S_IDLE;
            bus.sys_idle <= 1'b1;
            us_cnt       <= '0;
          end
        end

        S_CHECK: begin
          us_cnt <= '0;
          if (frame[7:0] == chk_sum) begin
            state    <= S_CONVERT;
            hum_bin  <= sat999(frame[39:24]);
            tmp_bin  <= sat999({1'b0, frame[22:8]});
            neg_q    <= frame[23];
            hum_acc  <= '0;
            tmp_acc  <= '0;
            conv_cnt <= '0;
          end else begin
            state        <= S_IDLE;
            bus.sys_idle <= 1'b1;
          end
        end

        S_CONVERT: begin
          // Both words are 10 bits after saturation: 10 dabble steps each.
          hum_acc  <= dd_step(hum_acc, hum_bin[9]);
          tmp_acc  <= dd_step(tmp_acc, tmp_bin[9]);
          hum_bin  <= {hum_bin[8:0], 1'b0};
          tmp_bin  <= {tmp_bin[8:0], 1'b0};
          conv_cnt <= conv_cnt + 4'd1;
          if (conv_cnt == 4'd9) begin
            state  <= S_DONE;
            us_cnt <= '0;
          end
        end

        S_DONE: begin
          bus.humidity_bcd    <= hum_acc;
          bus.temperature_bcd <= tmp_acc;
          bus.negativo_temp   <= neg_q;
          bus.data_ready      <= 1'b1;
          bus.sys_idle        <= 1'b1;
          state               <= S_IDLE;
          us_cnt              <= '0;
        end

        default: begin
          state        <= S_IDLE;
          drive_low    <= 1'b0;
          bus.sys_idle <= 1'b1;
          us_cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht22_reader.sv
`timescale 1ns/1ns
// Bench for dht22_reader at 1 MHz (one clock per microsecond).
module tb_dht22_reader;

  logic clk = 1'b0;
  logic arstn;
  logic sens_low;
  wire  dht_line;

  dht22_reader_if bus();

  dht22_reader #(.CLK_FREQ(1_000_000)) dut (
    .clk          (clk),
    .arstn        (arstn),
    .bus          (bus),
    .dht22_in_out (dht_line)
  );

  // Sensor side of the open-drain line plus the board pull-up.
  assign dht_line = sens_low ? 1'b0 : 1'bz;
  pullup (dht_line);

  always #500 clk = ~clk;

  int total = 0;
  int bad = 0;
  int dr_seen = 0;
  int dr_expect = 0;
  logic prev_dr = 1'b0;

  typedef struct {
    logic [11:0] h;
    logic [11:0] t;
    logic        n;
  } exp_t;

  exp_t q[$];
  exp_t held = '{12'h000, 12'h000, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Decimal digits of a tenths value, saturating at 99.9.
  function automatic logic [11:0] to_bcd(input int v);
    int s;
    s = (v > 999) ? 999 : v;
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [39:0] make_frame(input logic [15:0] hum, input logic [15:0] tmp);
    logic [7:0] cs;
    cs = hum[15:8] + hum[7:0] + tmp[15:8] + tmp[7:0];
    return {hum, tmp, cs};
  endfunction

  // Per-cycle compare: outputs must equal the last expected result, change only
  // with a one-cycle data_ready, and every data_ready must have been expected.
  always @(negedge clk) begin
    if (arstn === 1'b1) begin
      if (bus.data_ready === 1'b1) begin
        dr_seen++;
        check("dr_expected", (q.size() != 0), 1);
        check("dr_single_cycle", prev_dr, 0);
        if (q.size() != 0) held = q.pop_front();
      end
      check("hum_hold", bus.humidity_bcd, held.h);
      check("temp_hold", bus.temperature_bcd, held.t);
      check("neg_hold", bus.negativo_temp, held.n);
      prev_dr = bus.data_ready;
    end
  end

  // Acts as the sensor: measures the host start pulse, then replies with
  // nbits of frame f. nbits<0: stays silent. 0<nbits<40: stops after the
  // rising edge that begins the high phase of bit nbits-1.
  task automatic sensor_frame(input logic [39:0] f, input int nbits, input bit poke,
                              output int host_low);
    int n;
    n = 0;
    host_low = 0;
    while (dht_line !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (dht_line !== 1'b0) return;
    while (dht_line === 1'b0 && host_low < 1500) begin
      @(negedge clk);
      host_low++;
    end
    if (nbits < 0) return;
    repeat (30) @(negedge clk);
    sens_low = 1'b1;
    repeat (80) @(negedge clk);
    sens_low = 1'b0;
    repeat (80) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sens_low = 1'b1;
      if (poke && i == 5) begin
        bus.start_read = 1'b1;
        @(negedge clk);
        bus.start_read = 1'b0;
        check("busy_not_idle", bus.sys_idle, 0);
        repeat (49) @(negedge clk);
      end else begin
        repeat (50) @(negedge clk);
      end
      sens_low = 1'b0;
      if (i == nbits - 1 && nbits < 40) return;
      repeat (f[39-i] ? 70 : 27) @(negedge clk);
    end
    sens_low = 1'b1;
    repeat (50) @(negedge clk);
    sens_low = 1'b0;
  endtask

  task automatic do_read(input logic [39:0] f, input int nbits, input bit poke, input bit good);
    int host_low;
    if (good) begin
      q.push_back('{to_bcd(int'(f[39:24])), to_bcd(int'(f[22:8])), f[23]});
      dr_expect++;
    end
    bus.start_read = 1'b1;
    @(negedge clk);
    bus.start_read = 1'b0;
    check("sys_idle_drop", bus.sys_idle, 0);
    sensor_frame(f, nbits, poke, host_low);
    check_range("start_low_us", host_low, 995, 1005);
  endtask

  task automatic wait_idle(input int limit, output int cyc);
    cyc = 0;
    while (bus.sys_idle !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish_read(input string name);
    int cyc;
    wait_idle(100, cyc);
    check({name, "_idle"}, bus.sys_idle, 1);
    check({name, "_dr_count"}, dr_seen, dr_expect);
    repeat (300) @(negedge clk);
  endtask

  initial begin
    int cyc;
    logic [39:0] f;
    logic [15:0] hum, mag;
    logic sign;

    arstn = 1'b0;
    sens_low = 1'b0;
    bus.start_read = 1'b0;
    repeat (52) @(negedge clk);
    check("rst_sys_idle", bus.sys_idle, 1);
    check("rst_data_ready", bus.data_ready, 0);
    check("rst_hum", bus.humidity_bcd, 0);
    check("rst_temp", bus.temperature_bcd, 0);
    check("rst_neg", bus.negativo_temp, 0);
    check("rst_line", dht_line, 1);
    arstn = 1'b1;
    repeat (5) @(negedge clk);

    // Negative temperature frame.
    do_read(40'h028C_80FB_09, 40, 1'b0, 1'b1);
    finish_read("f1");
    check("f1_hum", bus.humidity_bcd, 12'h652);
    check("f1_temp", bus.temperature_bcd, 12'h251);
    check("f1_neg", bus.negativo_temp, 1);
    check("f1_line", dht_line, 1);

    // Upper humidity boundary, zero temperature.
    do_read(40'h03E7_0000_EA, 40, 1'b0, 1'b1);
    finish_read("f2");
    check("f2_hum", bus.humidity_bcd, 12'h999);
    check("f2_temp", bus.temperature_bcd, 12'h000);
    check("f2_neg", bus.negativo_temp, 0);

    // Bad checksum: nothing reported, outputs kept.
    f = make_frame(16'd345, 16'd200);
    f[7:0] = f[7:0] + 8'd1;
    do_read(f, 40, 1'b0, 1'b0);
    finish_read("cksum");
    check("cksum_hum_kept", bus.humidity_bcd, 12'h999);
    check("cksum_temp_kept", bus.temperature_bcd, 12'h000);

    // Silent sensor: abort about 200 us after the host releases the line.
    do_read(40'h0, -1, 1'b0, 1'b0);
    wait_idle(400, cyc);
    check_range("silent_timeout_us", cyc, 190, 215);
    finish_read("silent");

    // Truncated after bit 17: abort about 200 us after the last edge.
    do_read(make_frame(16'd500, 16'd250), 17, 1'b0, 1'b0);
    wait_idle(400, cyc);
    check_range("trunc_timeout_us", cyc, 190, 215);
    finish_read("trunc");
    check("trunc_hum_kept", bus.humidity_bcd, 12'h999);

    // Recovery with a good frame.
    do_read(make_frame(16'd123, 16'h8000 | 16'd45), 40, 1'b0, 1'b1);
    finish_read("recover");
    check("recover_hum", bus.humidity_bcd, 12'h123);
    check("recover_temp", bus.temperature_bcd, 12'h045);
    check("recover_neg", bus.negativo_temp, 1);

    // Random frames, each with a stray start_read mid-read.
    for (int k = 0; k < 5; k++) begin
      hum  = 16'($urandom_range(0, 999));
      mag  = 16'($urandom_range(0, 900));
      sign = 1'($urandom_range(0, 1));
      do_read(make_frame(hum, {sign, mag[14:0]}), 40, 1'b1, 1'b1);
      finish_read("rand");
    end

    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
